// File: rtl/spi_master_16.sv
// Single-frame SPI mode-0 master: shifts one DATA_W word out on mosi MSB first
// while capturing miso, then returns the received word with a one-cycle done.
module spi_master_16 #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              ss
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(SS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [GW-1:0]     gap_cnt, gap_cnt_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] tx_sh, tx_sh_nxt, rx_sh, rx_sh_nxt, rx_data_nxt;
  logic              busy_nxt, done_nxt, sclk_nxt, mosi_nxt, ss_nxt;
  logic              phase_end;

  assign phase_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ss      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_sh   <= tx_sh_nxt;
      rx_sh   <= rx_sh_nxt;
      rx_data <= rx_data_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      sclk    <= sclk_nxt;
      mosi    <= mosi_nxt;
      ss      <= ss_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    gap_cnt_nxt = '0;
    bit_cnt_nxt = bit_cnt;
    tx_sh_nxt   = tx_sh;
    rx_sh_nxt   = rx_sh;
    rx_data_nxt = rx_data;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    sclk_nxt    = sclk;
    mosi_nxt    = mosi;
    ss_nxt      = ss;
    // Every frame phase is exactly CLK_DIV cycles long.
    if (state inside {SETUP, SCK_HI, SCK_LO, HOLD})
      cnt_nxt = phase_end ? '0 : cnt + CW'(1);
    case (state)
      IDLE: if (start) begin
        tx_sh_nxt   = tx_data;
        rx_sh_nxt   = '0;
        bit_cnt_nxt = '0;
        ss_nxt      = 1'b0;
        mosi_nxt    = tx_data[DATA_W-1];
        busy_nxt    = 1'b1;
        state_nxt   = SETUP;
      end
      SETUP, SCK_LO: if (phase_end) begin
        sclk_nxt  = 1'b1;
        rx_sh_nxt = {rx_sh[DATA_W-2:0], miso};
        state_nxt = SCK_HI;
      end
      SCK_HI: if (phase_end) begin
        sclk_nxt = 1'b0;
        if (bit_cnt != BIT_LAST) begin
          tx_sh_nxt   = tx_sh << 1;
          mosi_nxt    = tx_sh[DATA_W-2];
          bit_cnt_nxt = bit_cnt + BW'(1);
          state_nxt   = SCK_LO;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD: if (phase_end) begin
        ss_nxt      = 1'b1;
        mosi_nxt    = 1'b0;
        rx_data_nxt = rx_sh;
        done_nxt    = 1'b1;
        state_nxt   = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
